// File: rtl/training_sequencer.sv
// training_sequencer: replays a gate truth table to the perceptron core each epoch, then feeds it debounced switches.
// Optional feature: define EARLY_STOP_EN to leave training at the first zero-error epoch.
package FixedPoint;
  typedef logic signed [15:0] sfp;
  localparam sfp ONE = 16'sh0100;
endpackage

module training_sequencer #(
  parameter int unsigned INPUT_UNITS     = 2,
  parameter int unsigned MAX_EPOCHS      = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned GATE_FUNC       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_UNITS-1:0] sw_in,
  output FixedPoint::sfp         values [INPUT_UNITS],
  output FixedPoint::sfp         expected,
  output logic                   training,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  input  FixedPoint::sfp         prediction,
  output logic                   converged,
  output logic [7:0]             epoch_count,
  output logic                   led
);
  import FixedPoint::*;

  localparam int unsigned IW = INPUT_UNITS;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {RST_WAIT, TRAIN, INFER} state_t;

  state_t          state;
  logic [IW-1:0]   idx, nxt;
  logic            epoch_err;
  logic            accept, pred_pos, err, epoch_bad, last_epoch, finish;

  logic [IW-1:0]   sync1, sync2, db;
  logic [CW-1:0]   cnt [INPUT_UNITS];

  function automatic logic label(input logic [IW-1:0] i);
    case (GATE_FUNC)
      0:       return &i;
      1:       return |i;
      2:       return ~&i;
      default: return ~|i;
    endcase
  endfunction

  function automatic sfp level(input logic b);
    return b ? ONE : sfp'(0);
  endfunction

  // A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int unsigned k = 0; k < INPUT_UNITS; k++) cnt[k] <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      for (int unsigned k = 0; k < INPUT_UNITS; k++) begin
        if (sync2[k] == db[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db[k]  <= sync2[k];
          cnt[k] <= '0;
        end else begin
          cnt[k] <= cnt[k] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    accept     = sample_valid && sample_ready;
    pred_pos   = prediction > sfp'(0);
    err        = pred_pos ^ (expected == ONE);
    epoch_bad  = epoch_err | err;
    last_epoch = ({1'b0, epoch_count} + 9'd1) == 9'(MAX_EPOCHS);
    nxt        = idx + IW'(1);
`ifdef EARLY_STOP_EN
    finish     = !epoch_bad || last_epoch;
`else
    finish     = last_epoch;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RST_WAIT;
      idx          <= '0;
      epoch_err    <= 1'b0;
      training     <= 1'b1;
      sample_valid <= 1'b0;
      converged    <= 1'b0;
      epoch_count  <= '0;
      led          <= 1'b0;
      expected     <= '0;
      for (int unsigned k = 0; k < INPUT_UNITS; k++) values[k] <= '0;
    end else begin
      case (state)
        RST_WAIT: begin
          state        <= TRAIN;
          sample_valid <= 1'b1;
          idx          <= '0;
          expected     <= level(label('0));
          for (int unsigned k = 0; k < INPUT_UNITS; k++) values[k] <= '0;
        end
        TRAIN: begin
          if (accept) begin
            epoch_err <= epoch_bad;
            if (idx != '1) begin
              idx      <= nxt;
              expected <= level(label(nxt));
              for (int unsigned k = 0; k < INPUT_UNITS; k++) values[k] <= level(nxt[k]);
            end else begin
              if (epoch_count != 8'hFF) epoch_count <= epoch_count + 8'd1;
              if (!epoch_bad) converged <= 1'b1;
              if (finish) begin
                state    <= INFER;
                training <= 1'b0;
                expected <= '0;
                for (int unsigned k = 0; k < INPUT_UNITS; k++) values[k] <= level(db[k]);
              end else begin
                idx       <= '0;
                epoch_err <= 1'b0;
                expected  <= level(label('0));
                for (int unsigned k = 0; k < INPUT_UNITS; k++) values[k] <= '0;
              end
            end
          end
        end
        INFER: begin
          expected <= '0;
          for (int unsigned k = 0; k < INPUT_UNITS; k++) values[k] <= level(db[k]);
          if (accept) led <= pred_pos;
        end
        default: state <= RST_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_training_sequencer.sv
// Self-checking bench for training_sequencer: randomized handshake/predictions against a truth-table model.
module tb_training_sequencer;
  import FixedPoint::*;

  localparam int unsigned IU = 2;
  localparam int unsigned ME = 10;
  localparam int unsigned DC = 16;
  localparam int unsigned GF = 0;
  localparam int unsigned N  = 2**IU;
`ifdef EARLY_STOP_EN
  localparam int unsigned GOOD_EPOCHS = 1;
`else
  localparam int unsigned GOOD_EPOCHS = ME;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [IU-1:0] sw_in = '0;
  sfp            values [IU];
  sfp            expected;
  sfp            prediction = '0;
  logic          training, sample_valid, converged, led;
  logic          sample_ready = 1'b0;
  logic [7:0]    epoch_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  training_sequencer #(
    .INPUT_UNITS(IU), .MAX_EPOCHS(ME), .DEBOUNCE_CYCLES(DC), .GATE_FUNC(GF)
  ) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .values(values), .expected(expected),
    .training(training), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .prediction(prediction), .converged(converged), .epoch_count(epoch_count), .led(led)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Target label from the number of ones in the sample index.
  function automatic bit truth(input int unsigned i);
    int unsigned ones = $countones(i);
    case (GF)
      0:       return ones == IU;
      1:       return ones != 0;
      2:       return ones != IU;
      default: return ones == 0;
    endcase
  endfunction

  task automatic check_reset(input string tag);
    for (int unsigned k = 0; k < IU; k++) chk({tag, ".values"}, values[k], 0);
    chk({tag, ".expected"}, expected, 0);
    chk({tag, ".training"}, training, 1);
    chk({tag, ".valid"}, sample_valid, 0);
    chk({tag, ".converged"}, converged, 0);
    chk({tag, ".epoch_count"}, epoch_count, 0);
    chk({tag, ".led"}, led, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
  endtask

  // pmode: 0 correct predictor, 1 always zero, 2 random. stop_after > 0 returns after that many accepts.
  task automatic train(input int pmode, input bit rand_ready, input int stop_after,
                       input int exp_epochs, input int exp_conv);
    int idx = 0, ep = 0, accepts = 0, cycles = 0;
    bit errs = 0, conv = 0, live = 1, rdy;
    sfp p;
    rst = 1'b0;
    sample_ready = 1'b1;
    chk("release.valid", sample_valid, 0);
    @(posedge clk);
    while (live && cycles < 5000) begin
      @(negedge clk);
      chk("train.valid", sample_valid, 1);
      chk("train.training", training, 1);
      for (int unsigned k = 0; k < IU; k++)
        chk("train.values", values[k], ((idx >> k) & 1) != 0 ? ONE : sfp'(0));
      chk("train.expected", expected, truth(idx) ? ONE : sfp'(0));
      chk("train.epoch_count", epoch_count, ep);
      chk("train.converged", converged, conv);
      if (stop_after > 0 && accepts == stop_after) return;
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      case (pmode)
        0:       p = truth(idx) ? sfp'($urandom_range(1, 32767)) : -sfp'($urandom_range(0, 32767));
        1:       p = '0;
        default: p = sfp'($urandom);
      endcase
      sample_ready = rdy;
      prediction   = p;
      @(posedge clk);
      cycles++;
      if (rdy) begin
        accepts++;
        errs = errs | ((p > 0) != truth(idx));
        if (idx < N - 1) begin
          idx++;
        end else begin
          ep++;
          if (!errs) conv = 1;
`ifdef EARLY_STOP_EN
          if (!errs || ep == ME) live = 0;
`else
          if (ep == ME) live = 0;
`endif
          idx  = 0;
          errs = 0;
        end
      end
    end
    if (live) begin
      n_total++;
      $error("FAIL train.timeout observed=%0d cycles expected=training to finish", cycles);
      return;
    end
    @(negedge clk);
    sample_ready = 1'b0;
    chk("done.training", training, 0);
    chk("done.valid", sample_valid, 1);
    chk("done.expected", expected, 0);
    chk("done.epoch_count", epoch_count, ep);
    chk("done.converged", converged, conv);
    if (exp_epochs >= 0) chk("done.epochs_spec", epoch_count, exp_epochs);
    if (exp_conv >= 0) chk("done.conv_spec", converged, exp_conv);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bit exp_led;
    bit rdy;
    sfp p;

    // Correct predictor, ready tied high.
    do_reset();
    train(0, 0, 0, GOOD_EPOCHS, 1);

    // Inference: glitch rejection, debounce latency, LED from prediction.
    for (int unsigned k = 0; k < IU; k++) chk("infer.init", values[k], 0);
    sw_in[0] = 1'b1;
    repeat (DC - 4) @(negedge clk);
    sw_in[0] = 1'b0;
    repeat (DC + 8) begin
      @(negedge clk);
      chk("infer.glitch", values[0], 0);
      chk("infer.training", training, 0);
    end
    sw_in[1] = 1'b1;
    repeat (DC + 2) @(posedge clk);
    #1 chk("infer.rise_early", values[1], 0);
    @(posedge clk);
    #1 chk("infer.rise", values[1], ONE);
    chk("infer.other", values[0], 0);
    @(negedge clk);
    sw_in[1] = 1'b0;
    repeat (DC + 2) @(posedge clk);
    #1 chk("infer.fall_early", values[1], ONE);
    @(posedge clk);
    #1 chk("infer.fall", values[1], 0);
    exp_led = 1'b0;
    repeat (12) begin
      @(negedge clk);
      rdy = 1'($urandom_range(0, 1));
      p   = sfp'($urandom);
      sample_ready = rdy;
      prediction   = p;
      @(posedge clk);
      if (rdy) exp_led = p > 0;
      #1 chk("infer.led", led, exp_led);
      chk("infer.expected", expected, 0);
    end

    // Predictor stuck at zero never converges.
    do_reset();
    train(1, 0, 0, ME, 0);

    // Random handshake and random predictions.
    do_reset();
    train(2, 1, 0, -1, -1);

    // Reset during epoch 3 at sample 2, then a full run with random ready.
    do_reset();
    train(1, 0, 2 * N + 2, -1, -1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("midreset");
    train(0, 1, 0, GOOD_EPOCHS, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
